// File: rtl/spim_seq.sv
// SPI flash transaction sequencer: walks chip-select, command, address, dummy
// and data phases, issuing one byte-engine operation at a time.
module spim_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [1:0]  cmd_mode,
  input  logic [31:0] addr,
  input  logic [2:0]  addr_bytes,
  input  logic [1:0]  addr_mode,
  input  logic [4:0]  dummy_cyc,
  input  logic        dir,
  input  logic [1:0]  data_mode,
  input  logic [15:0] dlen,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        busy,
  output logic        done,
  output logic        cs_n,
  output logic [1:0]  boper,
  output logic [1:0]  bmode,
  output logic [7:0]  tbyte,
  output logic [4:0]  dummy,
  input  logic [7:0]  rbyte,
  input  logic        bdone
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CSON  = 3'd1,
    CMD   = 3'd2,
    ADDR  = 3'd3,
    DUMMY = 3'd4,
    DATA  = 3'd5,
    CSOFF = 3'd6
  } state_t;

  typedef enum logic {
    PH_ISSUE = 1'b0,
    PH_WAIT  = 1'b1
  } phase_t;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_DUMMY = 2'd3;

  state_t      state_r, state_s;
  phase_t      phase_r, phase_s;
  logic        tick_r, tick_s;
  logic [7:0]  cmd_r, cmd_s;
  logic [1:0]  cmd_mode_r, cmd_mode_s;
  logic [31:0] addr_r, addr_s;
  logic [2:0]  acnt_r, acnt_s;
  logic [1:0]  addr_mode_r, addr_mode_s;
  logic [4:0]  dummy_cyc_r, dummy_cyc_s;
  logic        dir_r, dir_s;
  logic [1:0]  data_mode_r, data_mode_s;
  logic [15:0] dcnt_r, dcnt_s;

  logic        cs_n_s, busy_s, done_s, tx_ready_s, rx_valid_s;
  logic [1:0]  boper_s, bmode_s;
  logic [7:0]  tbyte_s, rx_data_s;
  logic [4:0]  dummy_s;

  // Reserved lane mode 3 degrades to single-lane.
  function automatic logic [1:0] lane(input logic [1:0] m);
    if (m == 2'd3) begin
      return 2'd0;
    end else begin
      return m;
    end
  endfunction

  // Phase that follows the current one, given what is still left to do.
  function automatic state_t route(input logic [2:0] ab, input logic [4:0] dc,
                                   input logic [15:0] dl);
    if (ab != 3'd0) begin
      return ADDR;
    end else if (dc != 5'd0) begin
      return DUMMY;
    end else if (dl != 16'd0) begin
      return DATA;
    end else begin
      return CSOFF;
    end
  endfunction

  // Address byte sent when n bytes remain; the most significant goes first.
  function automatic logic [7:0] addr_byte(input logic [31:0] a, input logic [2:0] n);
    case (n)
      3'd4:    return a[31:24];
      3'd3:    return a[23:16];
      3'd2:    return a[15:8];
      default: return a[7:0];
    endcase
  endfunction

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    tick_s      = tick_r;
    cmd_s       = cmd_r;
    cmd_mode_s  = cmd_mode_r;
    addr_s      = addr_r;
    acnt_s      = acnt_r;
    addr_mode_s = addr_mode_r;
    dummy_cyc_s = dummy_cyc_r;
    dir_s       = dir_r;
    data_mode_s = data_mode_r;
    dcnt_s      = dcnt_r;
    cs_n_s      = cs_n;
    busy_s      = busy;
    done_s      = 1'b0;
    boper_s     = 2'd0;
    bmode_s     = bmode;
    tbyte_s     = tbyte;
    dummy_s     = dummy;
    rx_valid_s  = rx_valid & ~rx_ready;
    rx_data_s   = rx_data;

    case (state_r)
      IDLE: begin
        if (start) begin
          cmd_s       = cmd;
          cmd_mode_s  = lane(cmd_mode);
          addr_s      = addr;
          acnt_s      = (addr_bytes > 3'd4) ? 3'd4 : addr_bytes;
          addr_mode_s = lane(addr_mode);
          dummy_cyc_s = dummy_cyc;
          dir_s       = dir;
          data_mode_s = lane(data_mode);
          dcnt_s      = dlen;
          busy_s      = 1'b1;
          cs_n_s      = 1'b0;
          tick_s      = 1'b0;
          state_s     = CSON;
        end else begin
          state_s = IDLE;
        end
      end

      CSON: begin
        if (tick_r) begin
          tick_s  = 1'b0;
          phase_s = PH_ISSUE;
          state_s = CMD;
        end else begin
          tick_s = 1'b1;
        end
      end

      CMD: begin
        if (phase_r == PH_ISSUE) begin
          boper_s = OP_WRITE;
          bmode_s = cmd_mode_r;
          tbyte_s = cmd_r;
          phase_s = PH_WAIT;
        end else if (bdone) begin
          phase_s = PH_ISSUE;
          state_s = route(acnt_r, dummy_cyc_r, dcnt_r);
        end else begin
          phase_s = PH_WAIT;
        end
      end

      ADDR: begin
        if (phase_r == PH_ISSUE) begin
          boper_s = OP_WRITE;
          bmode_s = addr_mode_r;
          tbyte_s = addr_byte(addr_r, acnt_r);
          phase_s = PH_WAIT;
        end else if (bdone) begin
          acnt_s  = acnt_r - 3'd1;
          phase_s = PH_ISSUE;
          if (acnt_r == 3'd1) begin
            state_s = route(3'd0, dummy_cyc_r, dcnt_r);
          end else begin
            state_s = ADDR;
          end
        end else begin
          phase_s = PH_WAIT;
        end
      end

      DUMMY: begin
        if (phase_r == PH_ISSUE) begin
          boper_s = OP_DUMMY;
          bmode_s = 2'd0;
          dummy_s = dummy_cyc_r;
          phase_s = PH_WAIT;
        end else if (bdone) begin
          phase_s = PH_ISSUE;
          state_s = route(3'd0, 5'd0, dcnt_r);
        end else begin
          phase_s = PH_WAIT;
        end
      end

      DATA: begin
        if (phase_r == PH_ISSUE) begin
          if (dir_r) begin
            // A read only issues once the previous byte has been taken.
            if (rx_valid && !rx_ready) begin
              phase_s = PH_ISSUE;
            end else if (dcnt_r == 16'd0) begin
              state_s = CSOFF;
            end else begin
              boper_s = OP_READ;
              bmode_s = data_mode_r;
              phase_s = PH_WAIT;
            end
          end else if (tx_valid && tx_ready) begin
            boper_s = OP_WRITE;
            bmode_s = data_mode_r;
            tbyte_s = tx_data;
            phase_s = PH_WAIT;
          end else begin
            phase_s = PH_ISSUE;
          end
        end else if (bdone) begin
          dcnt_s  = dcnt_r - 16'd1;
          phase_s = PH_ISSUE;
          if (dir_r) begin
            rx_valid_s = 1'b1;
            rx_data_s  = rbyte;
          end else if (dcnt_r == 16'd1) begin
            state_s = CSOFF;
          end else begin
            state_s = DATA;
          end
        end else begin
          phase_s = PH_WAIT;
        end
      end

      CSOFF: begin
        if (tick_r) begin
          tick_s  = 1'b0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          tick_s = 1'b1;
        end
      end

      default: begin
        state_s = IDLE;
        phase_s = PH_ISSUE;
        tick_s  = 1'b0;
        cs_n_s  = 1'b1;
        busy_s  = 1'b0;
      end
    endcase

    if ((state_s == CSOFF) && (state_r != CSOFF)) begin
      cs_n_s = 1'b1;
      tick_s = 1'b0;
    end else begin
      cs_n_s = cs_n_s;
    end

    tx_ready_s = (state_s == DATA) && (phase_s == PH_ISSUE) && !dir_r && (dcnt_s != 16'd0);
  end

  // State, configuration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      phase_r     <= PH_ISSUE;
      tick_r      <= 1'b0;
      cmd_r       <= 8'd0;
      cmd_mode_r  <= 2'd0;
      addr_r      <= 32'd0;
      acnt_r      <= 3'd0;
      addr_mode_r <= 2'd0;
      dummy_cyc_r <= 5'd0;
      dir_r       <= 1'b0;
      data_mode_r <= 2'd0;
      dcnt_r      <= 16'd0;
      cs_n        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      boper       <= 2'd0;
      bmode       <= 2'd0;
      tbyte       <= 8'd0;
      dummy       <= 5'd0;
      tx_ready    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= 8'd0;
    end else begin
      state_r     <= state_s;
      phase_r     <= phase_s;
      tick_r      <= tick_s;
      cmd_r       <= cmd_s;
      cmd_mode_r  <= cmd_mode_s;
      addr_r      <= addr_s;
      acnt_r      <= acnt_s;
      addr_mode_r <= addr_mode_s;
      dummy_cyc_r <= dummy_cyc_s;
      dir_r       <= dir_s;
      data_mode_r <= data_mode_s;
      dcnt_r      <= dcnt_s;
      cs_n        <= cs_n_s;
      busy        <= busy_s;
      done        <= done_s;
      boper       <= boper_s;
      bmode       <= bmode_s;
      tbyte       <= tbyte_s;
      dummy       <= dummy_s;
      tx_ready    <= tx_ready_s;
      rx_valid    <= rx_valid_s;
      rx_data     <= rx_data_s;
    end
  end

endmodule

// File: tb/tb_spim_seq.sv
// Self-checking bench for spim_seq: a behavioural byte engine, tx source and
// rx sink around the DUT, checked against a transaction-level op-list model.
module tb_spim_seq;

  logic        clk;
  logic        rst_n, start;
  logic [7:0]  cmd;
  logic [1:0]  cmd_mode;
  logic [31:0] addr;
  logic [2:0]  addr_bytes;
  logic [1:0]  addr_mode;
  logic [4:0]  dummy_cyc;
  logic        dir;
  logic [1:0]  data_mode;
  logic [15:0] dlen;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        busy, done, cs_n;
  logic [1:0]  boper, bmode;
  logic [7:0]  tbyte;
  logic [4:0]  dummy;
  logic [7:0]  rbyte;
  logic        bdone, eng_bdone, stray_bdone;

  assign bdone = eng_bdone | stray_bdone;

  spim_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .cmd_mode(cmd_mode),
    .addr(addr), .addr_bytes(addr_bytes), .addr_mode(addr_mode),
    .dummy_cyc(dummy_cyc), .dir(dir), .data_mode(data_mode), .dlen(dlen),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .cs_n(cs_n), .boper(boper), .bmode(bmode),
    .tbyte(tbyte), .dummy(dummy), .rbyte(rbyte), .bdone(bdone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [1:0]  cm;
    logic [31:0] addr;
    logic [2:0]  ab;
    logic [1:0]  am;
    logic [4:0]  dc;
    logic        dir;
    logic [1:0]  dm;
    logic [15:0] dlen;
    int          rx_stall;
    int          tx_stall_idx;
    int          tx_stall_len;
    int          tx_prob;
    int          rx_prob;
    bit          mid;
    int          exp_ops;
  } vec_t;

  int n_chk, n_fail;
  logic [16:0] obs_q[$], exp_q[$];
  logic [7:0]  tx_q[$], exp_rx[$];
  int done_cnt, cs_hi, viol, stall_obs, viol_stall, stall_left, stall_idx;
  int tx_sent, tx_prob, rx_prob, rx_stall_left, rx_got, lat;
  bit pending, prev_block;
  logic [1:0] pend_op;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Op fingerprint; fields the op does not define are masked out.
  function automatic logic [16:0] key(input logic [1:0] op, input logic [1:0] m,
                                      input logic [7:0] b, input logic [4:0] d);
    logic [1:0] mm;
    logic [7:0] bb;
    logic [4:0] dd;
    mm = (op == 2'd3) ? 2'd0 : m;
    bb = (op == 2'd2) ? b : 8'd0;
    dd = (op == 2'd3) ? d : 5'd0;
    return {op, mm, bb, dd};
  endfunction

  function automatic logic [1:0] lanes(input logic [1:0] m);
    return (m == 2'd3) ? 2'd0 : m;
  endfunction

  function automatic vec_t mk(input logic [7:0] c, input logic [1:0] cm, input logic [31:0] a,
                              input logic [2:0] ab, input logic [1:0] am, input logic [4:0] dc,
                              input logic d, input logic [1:0] dm, input logic [15:0] dl,
                              input int rxs, input int tsi, input int tsl, input int eo);
    vec_t v;
    v.cmd = c; v.cm = cm; v.addr = a; v.ab = ab; v.am = am; v.dc = dc;
    v.dir = d; v.dm = dm; v.dlen = dl; v.rx_stall = rxs; v.tx_stall_idx = tsi;
    v.tx_stall_len = tsl; v.tx_prob = 100; v.rx_prob = 100; v.mid = 1'b0; v.exp_ops = eo;
    return v;
  endfunction

  // Bus functional models: byte engine, monitor, tx source, rx sink.
  initial begin
    eng_bdone = 1'b0; rbyte = 8'd0; tx_valid = 1'b0; tx_data = 8'd0; rx_ready = 1'b0;
    pending = 1'b0; prev_block = 1'b0; lat = 0; pend_op = 2'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 1'b0; eng_bdone = 1'b0; prev_block = 1'b0;
      end else begin
        if (boper != 2'd0) begin
          if (pending) viol++;
          if (cs_n) viol++;
          if (boper == 2'd1 && prev_block) viol++;
          obs_q.push_back(key(boper, bmode, tbyte, dummy));
        end
        if (eng_bdone) begin
          eng_bdone = 1'b0;
          pending = 1'b0;
        end else if (pending) begin
          lat--;
          if (lat == 0) begin
            eng_bdone = 1'b1;
            rbyte = 8'($urandom);
            if (pend_op == 2'd1) exp_rx.push_back(rbyte);
          end
        end
        if (boper != 2'd0) begin
          pending = 1'b1; pend_op = boper; lat = int'($urandom_range(3, 1));
        end
        if (done) begin
          done_cnt++;
          if (busy) viol++;
        end
        if (busy && cs_n) cs_hi++;
        if (tx_q.size() > 0) begin
          tx_data = tx_q[0];
          if (tx_sent == stall_idx && stall_left > 0) begin
            tx_valid = 1'b0;
            if (tx_ready) begin
              stall_left--; stall_obs++;
              if (boper != 2'd0) viol_stall++;
            end
          end else begin
            tx_valid = (int'($urandom_range(99)) < tx_prob);
          end
          if (tx_valid && tx_ready) begin
            void'(tx_q.pop_front());
            tx_sent++;
          end
        end else begin
          tx_valid = 1'b0;
        end
        if (rx_stall_left > 0 && rx_valid) begin
          rx_ready = 1'b0;
          rx_stall_left--;
        end else begin
          rx_ready = (int'($urandom_range(99)) < rx_prob);
        end
        if (rx_valid && rx_ready) begin
          rx_got++;
          if (exp_rx.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rx_extra: got byte %0h, expected none", rx_data);
          end else begin
            chk("rx_byte", int'(rx_data), int'(exp_rx.pop_front()));
          end
        end
        prev_block = rx_valid && !rx_ready;
      end
    end
  end

  task automatic prep(input vec_t v);
    logic [7:0] txb[$];
    int n;
    txb.delete();
    if (!v.dir) begin
      for (int j = 0; j < int'(v.dlen); j++) txb.push_back(8'($urandom));
    end
    exp_q.delete();
    exp_q.push_back(key(2'd2, lanes(v.cm), v.cmd, 5'd0));
    n = (v.ab > 3'd4) ? 4 : int'(v.ab);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(key(2'd2, lanes(v.am), 8'(v.addr >> (8 * i)), 5'd0));
    if (v.dc != 5'd0) exp_q.push_back(key(2'd3, 2'd0, 8'd0, v.dc));
    for (int j = 0; j < int'(v.dlen); j++) begin
      if (v.dir) exp_q.push_back(key(2'd1, lanes(v.dm), 8'd0, 5'd0));
      else       exp_q.push_back(key(2'd2, lanes(v.dm), txb[j], 5'd0));
    end
    obs_q.delete(); exp_rx.delete();
    done_cnt = 0; cs_hi = 0; viol = 0; stall_obs = 0; viol_stall = 0; tx_sent = 0; rx_got = 0;
    tx_q = txb; stall_idx = v.tx_stall_idx; stall_left = v.tx_stall_len;
    tx_prob = v.tx_prob; rx_prob = v.rx_prob; rx_stall_left = v.rx_stall;
    cmd = v.cmd; cmd_mode = v.cm; addr = v.addr; addr_bytes = v.ab; addr_mode = v.am;
    dummy_cyc = v.dc; dir = v.dir; data_mode = v.dm; dlen = v.dlen;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    // Scramble the inputs: nothing may leak into the running transaction.
    cmd = ~v.cmd; addr = ~v.addr; addr_bytes = 3'd0; dummy_cyc = 5'd0;
    dir = ~v.dir; dlen = 16'd7; cmd_mode = 2'd1; data_mode = 2'd1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int c;
    prep(v);
    c = 0;
    while (c < 20000 && done_cnt == 0) begin
      @(negedge clk); #1;
      if (c == 6 && v.mid && busy) start = 1'b1;
      else start = 1'b0;
      c++;
    end
    start = 1'b0;
    if (done_cnt == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s done_timeout: no done within %0d cycles", tag, c);
    end
    repeat (3) @(negedge clk);
    #1;
    chk({tag, " op_count"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < obs_q.size()) chk($sformatf("%s op%0d", tag, k), int'(obs_q[k]), int'(exp_q[k]));
    end
    if (v.exp_ops >= 0) chk({tag, " table_ops"}, obs_q.size(), v.exp_ops);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " cs_high_cycles"}, cs_hi, 2);
    chk({tag, " protocol_violations"}, viol, 0);
    chk({tag, " rx_count"}, rx_got, v.dir ? int'(v.dlen) : 0);
    chk({tag, " rx_leftover"}, exp_rx.size(), 0);
    chk({tag, " tx_leftover"}, tx_q.size(), 0);
    chk({tag, " idle_busy"}, int'(busy), 0);
    chk({tag, " idle_cs_n"}, int'(cs_n), 1);
    if (v.tx_stall_len > 0) begin
      chk({tag, " tx_stall_cycles"}, stall_obs, v.tx_stall_len);
      chk({tag, " tx_stall_issue"}, viol_stall, 0);
    end
    if (v.rx_stall > 0) chk({tag, " rx_stall_done"}, rx_stall_left, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    int c;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; stray_bdone = 1'b0;
    cmd = 8'd0; cmd_mode = 2'd0; addr = 32'd0; addr_bytes = 3'd0; addr_mode = 2'd0;
    dummy_cyc = 5'd0; dir = 1'b0; data_mode = 2'd0; dlen = 16'd0;
    tx_prob = 100; rx_prob = 100; stall_idx = -1; stall_left = 0; rx_stall_left = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst cs_n", int'(cs_n), 1);
    chk("rst boper", int'(boper), 0);
    chk("rst bmode", int'(bmode), 0);
    chk("rst tbyte", int'(tbyte), 0);
    chk("rst dummy", int'(dummy), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst tx_ready", int'(tx_ready), 0);
    chk("rst rx_valid", int'(rx_valid), 0);
    chk("rst rx_data", int'(rx_data), 0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    tbl[0] = mk(8'h06, 2'd0, 32'h0,        3'd0, 2'd0, 5'd0,  1'b0, 2'd0, 16'd0,   0, -1, 0, 1);
    tbl[1] = mk(8'h0B, 2'd0, 32'h00123456, 3'd3, 2'd0, 5'd8,  1'b1, 2'd0, 16'd4,   0, -1, 0, 9);
    tbl[2] = mk(8'h32, 2'd0, 32'h000A0B0C, 3'd3, 2'd0, 5'd0,  1'b0, 2'd2, 16'd3,   0,  1, 5, 7);
    tbl[3] = mk(8'h03, 2'd0, 32'h00654321, 3'd3, 2'd0, 5'd0,  1'b1, 2'd0, 16'd2,  10, -1, 0, 6);
    tbl[4] = mk(8'hA5, 2'd3, 32'hDEADBEEF, 3'd7, 2'd1, 5'd0,  1'b0, 2'd1, 16'd1,   0, -1, 0, 6);
    tbl[5] = mk(8'h5A, 2'd1, 32'h0,        3'd0, 2'd0, 5'd31, 1'b1, 2'd0, 16'd0,   0, -1, 0, 2);
    tbl[6] = mk(8'hEB, 2'd0, 32'h11223344, 3'd4, 2'd2, 5'd4,  1'b1, 2'd2, 16'd3,   0, -1, 0, 9);
    tbl[7] = mk(8'h38, 2'd2, 32'h0,        3'd0, 2'd0, 5'd0,  1'b0, 2'd2, 16'd300, 0, -1, 0, 301);
    tbl[1].mid = 1'b1;
    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Stray bdone while idle must change nothing.
    obs_q.delete(); done_cnt = 0;
    stray_bdone = 1'b1;
    @(negedge clk); #1;
    stray_bdone = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("stray busy", int'(busy), 0);
    chk("stray cs_n", int'(cs_n), 1);
    chk("stray boper", int'(boper), 0);
    chk("stray done", done_cnt, 0);
    chk("stray ops", obs_q.size(), 0);
    run_txn(tbl[0], "after_stray");

    // Asynchronous reset while the address bytes are going out.
    v = mk(8'h02, 2'd0, 32'hCAFEF00D, 3'd4, 2'd0, 5'd0, 1'b0, 2'd0, 16'd2, 0, -1, 0, -1);
    prep(v);
    c = 0;
    while (c < 200 && obs_q.size() < 2) begin
      @(negedge clk); #1;
      c++;
    end
    chk("rst_mid reached_addr", int'(obs_q.size() >= 2), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid cs_n", int'(cs_n), 1);
    chk("rst_mid boper", int'(boper), 0);
    chk("rst_mid busy", int'(busy), 0);
    chk("rst_mid tx_ready", int'(tx_ready), 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    tx_q.delete();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid done", done_cnt, 0);
    chk("rst_mid busy_after", int'(busy), 0);
    run_txn(tbl[1], "after_rst");

    // Randomised transactions against the op-list model.
    for (int i = 0; i < 20; i++) begin
      v = mk(8'($urandom), 2'($urandom), $urandom, 3'($urandom), 2'($urandom),
             ($urandom_range(1) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), 2'($urandom),
             16'($urandom_range(6)), 0, -1, 0, -1);
      v.tx_prob = int'($urandom_range(100, 40));
      v.rx_prob = int'($urandom_range(100, 30));
      v.mid = 1'($urandom);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spim_seq.md
SPIM_SEQ -- requirements
Module: spim_seq

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 start  in  1  one-cycle pulse, sampled only in IDLE; launches one transaction.
REQ-004 cmd / cmd_mode  in  8 / 2  opcode byte / its lane mode (0=1bit, 1=2bit, 2=4bit; 3 reserved, treated as 1bit).
REQ-005 addr / addr_bytes / addr_mode  in  32 / 3 / 2  address, byte count 0..4 (>4 treated as 4), lane mode.
REQ-006 dummy_cyc  in  5  dummy clock count; 0 = no dummy phase.
REQ-007 dir / data_mode / dlen  in  1 / 2 / 16  0=write, 1=read; lane mode; data byte count (0 = no data phase).
REQ-008 tx_data / tx_valid / tx_ready  in / in / out  8 / 1 / 1  write-data stream; transfer when valid&ready.
REQ-009 rx_data / rx_valid / rx_ready  out / out / in  8 / 1 / 1  read-data stream; transfer when valid&ready.
REQ-010 busy / done  out  1 / 1  transaction active / one-cycle completion pulse.
REQ-011 cs_n  out  1  flash chip select, active-low.
REQ-012 boper / bmode / tbyte / dummy  out  2 / 2 / 8 / 5  byte-engine request (boper 0=none, 1=read, 2=write, 3=dummy).
REQ-013 rbyte / bdone  in  8 / 1  byte-engine result and one-cycle completion.

Function
REQ-014 States SHALL be IDLE, CSON, CMD, ADDR, DUMMY, DATA, CSOFF; per-op sub-phase ISSUE/WAIT.
REQ-015 Launch: start in IDLE SHALL capture all config inputs into registers, assert busy and cs_n=0 next cycle, enter CSON.
REQ-016 CSON SHALL last exactly 2 cycles, then go to CMD.
REQ-017 ISSUE SHALL drive boper non-zero for exactly one cycle with bmode/tbyte/dummy valid, then WAIT with boper=0.
REQ-018 WAIT SHALL end on bdone=1; the next ISSUE SHALL occur no earlier than the cycle after bdone.
REQ-019 CMD: one write op of cmd with cmd_mode; then ADDR if addr_bytes!=0, else DUMMY if dummy_cyc!=0, else DATA if dlen!=0, else CSOFF.
REQ-020 ADDR: addr_bytes write ops, MSB byte first (4 bytes: addr[31:24] first; 3 bytes: addr[23:16] first), mode addr_mode.
REQ-021 DUMMY: one dummy op with dummy=dummy_cyc; then DATA if dlen!=0 else CSOFF.
REQ-022 DATA write: per byte, tx_ready=1 only in ISSUE; ISSUE SHALL stall (boper=0) while tx_valid=0; accepted byte drives tbyte.
REQ-023 DATA read: each bdone SHALL latch rbyte into rx_data with rx_valid=1 held until rx_ready; next read op SHALL NOT issue while rx_valid=1 and rx_ready=0.
REQ-024 16-bit remaining-byte counter SHALL decrement once per completed data op; phase ends when it reaches 0; dlen=65535 SHALL be supported.
REQ-025 CSOFF: cs_n=1 for exactly 2 cycles (read: after final rx handshake), then done=1 one cycle, busy=0, IDLE.
REQ-026 start while busy SHALL be ignored; no config changes take effect mid-transaction.
REQ-027 bdone outside WAIT SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL force IDLE, cs_n=1, boper=0, bmode=0, tbyte=0, dummy=0, busy=0, done=0, tx_ready=0, rx_valid=0, rx_data=0, counters 0.
REQ-029 Reset mid-transaction SHALL abort immediately with no done pulse; no partial state after rst_n release.

Verification
REQ-030 cmd=0x06, addr_bytes=0, dummy_cyc=0, dlen=0 -> one write op 0x06, cs_n low->high, single done, total ops=1.
REQ-031 Read 0x0B, addr=0x00123456, 3 bytes, dummy_cyc=8, dlen=4 -> ops W0B,W12,W34,W56,D8,R,R,R,R; 4 rx bytes in order.
REQ-032 Write 0x32, data_mode=2, dlen=3, tx_valid low 5 cycles before byte 2 -> boper stays 0 for those cycles, bytes in order.
REQ-033 Read dlen=2, rx_ready low 10 cycles -> second read op not issued until first byte accepted; no byte lost.
REQ-034 rst_n pulsed during ADDR -> cs_n=1, boper=0, busy=0 asynchronously; next start runs a clean transaction.
REQ-035 start pulsed while busy, and stray bdone in IDLE -> no effect on sequence or outputs.
